// File: rtl/ahmes_pkg.sv
// Shared types and I/O map for the Ahmes datapath: ALU opcodes, flag bundle and
// memory-mapped I/O base addresses.
package ahmes_pkg;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SHLC = 4'd7,
    ALU_SHRC = 4'd8,
    ALU_SHL  = 4'd9,
    ALU_SHR  = 4'd10,
    ALU_ASR  = 4'd11,
    ALU_ROL  = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic b;
    logic v;
  } flags_t;

  localparam logic [7:0] IO_OUT_BASE = 8'h00;
  localparam logic [7:0] IO_IN_BASE  = 8'h04;
  localparam logic [7:0] IO_STATUS   = 8'h0F;

endpackage

// File: rtl/ahmes_io_debounce.sv
// One board input port: multi-flop synchroniser followed by a debounce counter
// that accepts a new value only after it has held for DEBOUNCE_CYC samples.
module ahmes_io_debounce
  import ahmes_pkg::*;
#(
  parameter int IN_W         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] pin_i,
  output logic [IN_W-1:0] stable_o,
  output logic            change_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
  logic [IN_W-1:0]                  cand;
  logic [IN_W-1:0]                  prev_q;
  logic [IN_W-1:0]                  stable_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 cnt_d;
  logic                             change_q;

  assign cand = sync_q[SYNC_STAGES-1];

  // A fresh candidate value restarts the run length at one sample.
  assign cnt_d = (cand != prev_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q   <= cand;
      change_q <= 1'b0;
      if (cand == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_d >= CNT_W'(DEBOUNCE_CYC)) begin
        stable_q <= cand;
        change_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign stable_o = stable_q;
  assign change_o = change_q;

endmodule

// File: rtl/ahmes_datapath_p.sv
// Ahmes datapath: PC, accumulator, ALU, status flags and a memory-mapped I/O
// bank with registered req/ack handshake, output ports and debounced inputs.
module ahmes_datapath_p
  import ahmes_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int N_OUT        = 2,
  parameter int OUT_W        = 4,
  parameter int N_IN         = 2,
  parameter int IN_W         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_load_en,
  input  logic                   pc_inc_en,
  input  logic                   ac_load_en,
  input  logic                   flags_load_en,
  input  alu_op_e                alu_op,
  input  logic                   alu_cin,
  input  logic [DATA_W-1:0]      data_bus_in,
  input  logic                   io_req,
  input  logic                   io_we,
  input  logic [7:0]             io_addr,
  input  logic [N_IN*IN_W-1:0]   in_ports,
  output logic [DATA_W-1:0]      pc_out,
  output logic [DATA_W-1:0]      ac_out,
  output logic                   io_ack,
  output logic [DATA_W-1:0]      io_rdata,
  output logic [N_OUT*OUT_W-1:0] out_ports,
  output logic                   flag_n,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   flag_b,
  output logic                   flag_v
);

  logic [DATA_W-1:0]      pc_q;
  logic [DATA_W-1:0]      ac_q;
  flags_t                 flags_q;
  logic                   io_ack_q;
  logic [DATA_W-1:0]      io_rdata_q;
  logic [N_OUT*OUT_W-1:0] out_q;
  logic [N_IN-1:0]        sticky_q;
  logic [N_IN-1:0]        sticky_d;

  logic [N_IN*IN_W-1:0]   in_stable;
  logic [N_IN-1:0]        in_change;

  logic [DATA_W-1:0]      alu_res;
  logic [DATA_W:0]        sum;
  logic                   alu_c;
  logic                   alu_b;
  logic                   alu_v;
  flags_t                 alu_flags;

  logic [DATA_W-1:0]      rd_mux;
  logic                   status_rd;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    ahmes_io_debounce #(
      .IN_W        (IN_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .pin_i   (in_ports[g*IN_W +: IN_W]),
      .stable_o(in_stable[g*IN_W +: IN_W]),
      .change_o(in_change[g])
    );
  end

  always_comb begin
    alu_res = '0;
    sum     = '0;
    alu_c   = 1'b0;
    alu_b   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_PASS: alu_res = data_bus_in;
      ALU_ADD: begin
        sum     = {1'b0, ac_q} + {1'b0, data_bus_in} + {{DATA_W{1'b0}}, alu_cin};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (ac_q[DATA_W-1] == data_bus_in[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != ac_q[DATA_W-1]);
      end
      ALU_SUB: begin
        sum     = {1'b0, ac_q} - {1'b0, data_bus_in};
        alu_res = sum[DATA_W-1:0];
        alu_b   = sum[DATA_W];
        alu_c   = ~sum[DATA_W];
        alu_v   = (ac_q[DATA_W-1] != data_bus_in[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != ac_q[DATA_W-1]);
      end
      ALU_OR:  alu_res = ac_q | data_bus_in;
      ALU_AND: alu_res = ac_q & data_bus_in;
      ALU_NOT: alu_res = ~ac_q;
      ALU_XOR: alu_res = ac_q ^ data_bus_in;
      ALU_SHLC: begin
        alu_res = {ac_q[DATA_W-2:0], alu_cin};
        alu_c   = ac_q[DATA_W-1];
      end
      ALU_SHRC: begin
        alu_res = {alu_cin, ac_q[DATA_W-1:1]};
        alu_c   = ac_q[0];
      end
      ALU_SHL: begin
        alu_res = {ac_q[DATA_W-2:0], 1'b0};
        alu_c   = ac_q[DATA_W-1];
      end
      ALU_SHR: begin
        alu_res = {1'b0, ac_q[DATA_W-1:1]};
        alu_c   = ac_q[0];
      end
      ALU_ASR: begin
        alu_res = {ac_q[DATA_W-1], ac_q[DATA_W-1:1]};
        alu_c   = ac_q[0];
      end
      ALU_ROL: begin
        alu_res = {ac_q[DATA_W-2:0], ac_q[DATA_W-1]};
        alu_c   = ac_q[DATA_W-1];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = '{n: alu_res[DATA_W-1], z: (alu_res == '0), c: alu_c, b: alu_b, v: alu_v};

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (io_addr == IO_OUT_BASE + 8'(i)) rd_mux[OUT_W-1:0] = out_q[i*OUT_W +: OUT_W];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (io_addr == IO_IN_BASE + 8'(i)) rd_mux[IN_W-1:0] = in_stable[i*IN_W +: IN_W];
    end
    if (io_addr == IO_STATUS) rd_mux[N_IN-1:0] = sticky_q;
  end

  // Read-clear only drops bits already seen; a change pulse on the same edge re-sets its bit.
  assign status_rd = io_req && !io_we && (io_addr == IO_STATUS);
  assign sticky_d  = (sticky_q & ~(status_rd ? sticky_q : '0)) | in_change;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      ac_q       <= '0;
      flags_q    <= '0;
      io_ack_q   <= 1'b0;
      io_rdata_q <= '0;
      out_q      <= '0;
      sticky_q   <= '0;
    end else begin
      if (pc_load_en)     pc_q <= data_bus_in;
      else if (pc_inc_en) pc_q <= pc_q + DATA_W'(1);
      if (ac_load_en)     ac_q <= alu_res;
      if (flags_load_en)  flags_q <= alu_flags;

      io_ack_q   <= io_req;
      io_rdata_q <= (io_req && !io_we) ? rd_mux : '0;
      if (io_req && io_we) begin
        for (int i = 0; i < N_OUT; i++) begin
          if (io_addr == IO_OUT_BASE + 8'(i)) out_q[i*OUT_W +: OUT_W] <= ac_q[OUT_W-1:0];
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign pc_out    = pc_q;
  assign ac_out    = ac_q;
  assign io_ack    = io_ack_q;
  assign io_rdata  = io_rdata_q;
  assign out_ports = out_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_b    = flags_q.b;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_ahmes_datapath_p.sv
// Directed bench for ahmes_datapath_p: stimulus pushes expected I/O read data
// into a scoreboard, a separate monitor pops it on every io_ack.
module tb_ahmes_datapath_p;
  import ahmes_pkg::*;

  localparam int DATA_W = 8, N_OUT = 2, OUT_W = 4, N_IN = 2, IN_W = 4;
  localparam int SYNC_STAGES = 2, DEBOUNCE_CYC = 4;
  localparam int LAT = SYNC_STAGES + DEBOUNCE_CYC;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pc_load_en, pc_inc_en, ac_load_en, flags_load_en;
  alu_op_e                alu_op;
  logic                   alu_cin;
  logic [DATA_W-1:0]      data_bus_in;
  logic                   io_req, io_we;
  logic [7:0]             io_addr;
  logic [N_IN*IN_W-1:0]   in_ports;
  logic [DATA_W-1:0]      pc_out, ac_out, io_rdata;
  logic                   io_ack;
  logic [N_OUT*OUT_W-1:0] out_ports;
  logic                   flag_n, flag_z, flag_c, flag_b, flag_v;

  ahmes_datapath_p #(
    .DATA_W(DATA_W), .N_OUT(N_OUT), .OUT_W(OUT_W), .N_IN(N_IN), .IN_W(IN_W),
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .pc_load_en(pc_load_en), .pc_inc_en(pc_inc_en),
    .ac_load_en(ac_load_en), .flags_load_en(flags_load_en), .alu_op(alu_op),
    .alu_cin(alu_cin), .data_bus_in(data_bus_in), .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .in_ports(in_ports), .pc_out(pc_out), .ac_out(ac_out),
    .io_ack(io_ack), .io_rdata(io_rdata), .out_ports(out_ports),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_b(flag_b), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {flag_n, flag_z, flag_c, flag_b, flag_v};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic alu(input alu_op_e op, input logic [7:0] bus, input logic cin,
                     input logic ld_ac, input logic ld_fl);
    alu_op = op; data_bus_in = bus; alu_cin = cin;
    ac_load_en = ld_ac; flags_load_en = ld_fl;
    tick();
    ac_load_en = 1'b0; flags_load_en = 1'b0; alu_cin = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    io_req = 1'b1; io_we = 1'b0; io_addr = a;
    sb.push_back('{exp, cyc, nm});
    tick();
    io_req = 1'b0;
  endtask

  task automatic io_wr(input logic [7:0] a, input string nm);
    io_req = 1'b1; io_we = 1'b1; io_addr = a;
    sb.push_back('{8'h00, cyc, nm});
    tick();
    io_req = 1'b0; io_we = 1'b0;
  endtask

  // Monitor: every ack must match the oldest outstanding request, one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io_ack) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: got ack with rdata 0x%0h, none outstanding", io_rdata);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_rdata"}, io_rdata, e.exp);
          check({e.nm, "_ack_cycle"}, cyc, e.cyc + 1);
        end
      end else begin
        check("rdata_idle", io_rdata, 0);
        if (sb.size() > 0 && cyc >= sb[0].cyc + 1) begin
          e = sb.pop_front();
          n_chk++; n_fail++;
          $display("FAIL %s_missing_ack: got no ack, expected ack at cycle %0d", e.nm, e.cyc + 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    pc_load_en = 1'b0; pc_inc_en = 1'b0; ac_load_en = 1'b0; flags_load_en = 1'b0;
    alu_op = ALU_PASS; alu_cin = 1'b0; data_bus_in = '0;
    io_req = 1'b0; io_we = 1'b0; io_addr = '0; in_ports = '0;
    repeat (3) tick();
    check("rst_pc", pc_out, 0);
    check("rst_ac", ac_out, 0);
    check("rst_ack", io_ack, 0);
    check("rst_out", out_ports, 0);
    check("rst_flags", flags(), 0);
    reset = 1'b0;
    tick();

    // ALU and flags ({n,z,c,b,v})
    alu(ALU_PASS, 8'h7F, 1'b0, 1'b1, 1'b0);
    check("pass_ac", ac_out, 8'h7F);
    alu(ALU_ADD, 8'h01, 1'b0, 1'b1, 1'b1);
    check("add_ac", ac_out, 8'h80);
    check("add_flags", flags(), 5'b10001);
    alu(ALU_PASS, 8'h00, 1'b0, 1'b1, 1'b1);
    check("pass0_flags", flags(), 5'b01000);
    alu(ALU_SUB, 8'h01, 1'b0, 1'b1, 1'b1);
    check("sub_ac", ac_out, 8'hFF);
    check("sub_flags", flags(), 5'b10010);
    alu(ALU_ADD, 8'h01, 1'b1, 1'b1, 1'b1);
    check("addc_ac", ac_out, 8'h01);
    check("addc_flags", flags(), 5'b00100);
    alu(ALU_PASS, 8'h81, 1'b0, 1'b1, 1'b0);
    alu(ALU_ASR, 8'h00, 1'b0, 1'b1, 1'b1);
    check("asr_ac", ac_out, 8'hC0);
    check("asr_flags", flags(), 5'b10100);
    alu(ALU_PASS, 8'h81, 1'b0, 1'b1, 1'b0);
    alu(ALU_ROL, 8'h00, 1'b0, 1'b1, 1'b1);
    check("rol_ac", ac_out, 8'h03);
    check("rol_flags", flags(), 5'b00100);
    alu(ALU_PASS, 8'h02, 1'b0, 1'b1, 1'b0);
    alu(ALU_SHRC, 8'h00, 1'b1, 1'b1, 1'b1);
    check("shrc_ac", ac_out, 8'h81);
    check("shrc_flags", flags(), 5'b10000);
    alu(alu_op_e'(4'd13), 8'h55, 1'b1, 1'b1, 1'b1);
    check("op13_ac", ac_out, 8'h00);
    check("op13_flags", flags(), 5'b01000);
    alu(ALU_PASS, 8'h80, 1'b0, 1'b1, 1'b0);
    check("noflag_ac", ac_out, 8'h80);
    check("noflag_flags", flags(), 5'b01000);

    // PC
    data_bus_in = 8'hFF; pc_load_en = 1'b1; tick(); pc_load_en = 1'b0;
    check("pc_load", pc_out, 8'hFF);
    pc_inc_en = 1'b1; tick();
    check("pc_wrap", pc_out, 8'h00);
    tick();
    check("pc_inc", pc_out, 8'h01);
    data_bus_in = 8'h3C; pc_load_en = 1'b1; tick();
    pc_load_en = 1'b0; pc_inc_en = 1'b0;
    check("pc_prio", pc_out, 8'h3C);

    // Output ports and I/O map
    alu(ALU_PASS, 8'hA5, 1'b0, 1'b1, 1'b0);
    io_wr(8'h01, "wr_out1");
    check("out_after_wr1", out_ports, 8'h50);
    io_rd(8'h01, 8'h05, "rd_out1");
    io_rd(8'h09, 8'h00, "rd_unmapped");
    alu(ALU_PASS, 8'h3C, 1'b0, 1'b1, 1'b0);
    io_wr(8'h00, "wr_out0");
    check("out_after_wr0", out_ports, 8'h5C);
    io_rd(8'h00, 8'h0C, "rd_out0");
    io_wr(8'h20, "wr_unmapped");
    io_wr(IO_STATUS, "wr_status");
    check("out_after_ignored_wr", out_ports, 8'h5C);
    io_rd(IO_IN_BASE, 8'h00, "rd_in0_idle");
    io_rd(IO_STATUS, 8'h00, "rd_status_idle");

    // Port 0: 2-cycle glitch must not be accepted
    for (int k = 0; k < 12; k++) begin
      in_ports[3:0] = (k < 2) ? 4'h9 : 4'h0;
      io_rd(IO_IN_BASE, 8'h00, "rd_in0_glitch");
    end
    io_rd(IO_STATUS, 8'h00, "rd_status_glitch");

    // Port 0: steady change appears exactly SYNC_STAGES+DEBOUNCE_CYC edges later
    in_ports[3:0] = 4'h9;
    for (int k = 0; k < LAT + 4; k++) begin
      io_rd(IO_IN_BASE, (k >= LAT) ? 8'h09 : 8'h00, "rd_in0_latency");
    end
    io_rd(IO_STATUS, 8'h01, "rd_status_p0");
    io_rd(IO_STATUS, 8'h00, "rd_status_p0_clr");

    // Port 1: second change pulse lands on the same edge as a STATUS read-clear
    in_ports[7:4] = 4'h3;
    repeat (12) tick();
    in_ports[7:4] = 4'h6;
    repeat (LAT) tick();
    io_rd(IO_STATUS, 8'h02, "rd_status_collide");
    io_rd(IO_STATUS, 8'h02, "rd_status_set_wins");
    io_rd(IO_STATUS, 8'h00, "rd_status_p1_clr");
    io_rd(IO_IN_BASE + 8'h01, 8'h06, "rd_in1");

    // Reset in the cycle after a read request
    io_req = 1'b1; io_we = 1'b0; io_addr = IO_IN_BASE;
    sb.push_back('{8'h09, cyc, "rd_before_reset"});
    tick();
    io_req = 1'b0; reset = 1'b1;
    tick();
    check("midrst_ack", io_ack, 0);
    check("midrst_rdata", io_rdata, 0);
    check("midrst_pc", pc_out, 0);
    check("midrst_ac", ac_out, 0);
    check("midrst_out", out_ports, 0);
    check("midrst_flags", flags(), 0);
    io_req = 1'b1; io_addr = IO_IN_BASE;
    tick();
    io_req = 1'b0;
    check("req_during_reset_ack", io_ack, 0);
    reset = 1'b0;
    tick();
    io_rd(IO_IN_BASE, 8'h00, "rd_in0_after_reset");
    io_rd(IO_STATUS, 8'h00, "rd_status_after_reset");

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
